// File: rtl/mdu_unit_pkg.sv
// Shared opcodes, latencies and result payload for the multiply/divide unit.
package mdu_unit_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned OP_W         = 4;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic [OP_W-1:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MTHI  = 4'd5,
        MDU_OP_MTLO  = 4'd6,
        MDU_OP_MFHI  = 4'd7,
        MDU_OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              divzero;
    } mdu_res_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational signed/unsigned multiply and divide producing the pending HI/LO pair.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output mdu_res_t          res_o
);

    logic [2*DATA_W-1:0] sprod;
    logic [2*DATA_W-1:0] uprod;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   div_b;
    logic [DATA_W-1:0]   uq;
    logic [DATA_W-1:0]   ur;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    always_comb begin
        sprod = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
        uprod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

        // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
        neg_a = (op_i == MDU_OP_DIV) && a_i[DATA_W-1];
        neg_b = (op_i == MDU_OP_DIV) && b_i[DATA_W-1];
        mag_a = neg_a ? (DATA_W'(0) - a_i) : a_i;
        mag_b = neg_b ? (DATA_W'(0) - b_i) : b_i;
        div_b = (mag_b == '0) ? DATA_W'(1) : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quot  = (neg_a ^ neg_b) ? (DATA_W'(0) - uq) : uq;
        rem   = neg_a ? (DATA_W'(0) - ur) : ur;

        res_o = '0;
        case (op_i)
            MDU_OP_MULT: begin
                res_o.hi = sprod[2*DATA_W-1:DATA_W];
                res_o.lo = sprod[DATA_W-1:0];
            end
            MDU_OP_MULTU: begin
                res_o.hi = uprod[2*DATA_W-1:DATA_W];
                res_o.lo = uprod[DATA_W-1:0];
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
                res_o.hi      = rem;
                res_o.lo      = quot;
                res_o.divzero = (b_i == '0);
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; a down-counter sequences the busy window and commit.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   MDUOp,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic [DATA_W-1:0] MDUOut
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] hi_q,   hi_d;
    logic [DATA_W-1:0] lo_q,   lo_d;
    mdu_res_t          pend_q, pend_d;
    mdu_res_t          calc_res;
    logic              launch;

    mdu_calc u_calc (
        .a_i   (A),
        .b_i   (B),
        .op_i  (MDUOp),
        .res_o (calc_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    // cnt_q == 0 is IDLE; any other value is RUN with that many busy cycles left.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        launch = (cnt_q == '0) && start && is_muldiv(MDUOp);

        if (launch) begin
            pend_d = calc_res;
            cnt_d  = is_div(MDUOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            busy_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
            if ((cnt_q == CNT_W'(1)) && !pend_q.divzero) begin
                hi_d = pend_q.hi;
                lo_d = pend_q.lo;
            end
        end else if (!busy_q && !start) begin
            if (MDUOp == MDU_OP_MTHI) hi_d = A;
            if (MDUOp == MDU_OP_MTLO) lo_d = A;
        end
    end

    always_comb begin
        case (MDUOp)
            MDU_OP_MFHI: MDUOut = hi_q;
            MDU_OP_MFLO: MDUOut = lo_q;
            default:     MDUOut = '0;
        endcase
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes expected commits, negedge monitor checks them.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  MDUOp = MDU_OP_NONE;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDUOut;

    mdu_unit #(.MULT_LAT(MULT_CYC), .DIV_LAT(DIV_CYC)) dut (
        .clk    (clk),
        .reset  (reset_n),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Reference arithmetic straight from the architectural definition.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        dz = 1'b0; hi = '0; lo = '0;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (op)
            MDU_OP_MULT:  begin p  = sa * sb; hi = p[63:32];  lo = p[31:0];  end
            MDU_OP_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            MDU_OP_DIV: begin
                if (b == 0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            MDU_OP_DIVU: begin
                if (b == 0) dz = 1'b1;
                else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
            end
            default: dz = 1'b1;
        endcase
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi, lo;
        bit dz;
        exp_t e;
        ref_op(op, a, b, hi, lo, dz);
        if (!dz) begin model_hi = hi; model_lo = lo; end
        e.hi = model_hi; e.lo = model_lo;
        e.cycles = (op == MDU_OP_DIV || op == MDU_OP_DIVU) ? DIV_CYC : MULT_CYC;
        @(negedge clk);
        A = a; B = b; MDUOp = op; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; MDUOp = MDU_OP_NONE;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        if (busy) chk("busy_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic read_check(input string tag);
        MDUOp = MDU_OP_MFHI; #1;
        chk({tag, "_mfhi"}, MDUOut, model_hi);
        MDUOp = MDU_OP_MFLO; #1;
        chk({tag, "_mflo"}, MDUOut, model_lo);
        MDUOp = MDU_OP_NONE;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        A = v; MDUOp = op; start = 1'b0;
        @(negedge clk);
        MDUOp = MDU_OP_NONE;
        if (op == MDU_OP_MTHI) model_hi = v;
        else model_lo = v;
    endtask

    // Monitor: counts busy cycles and checks HI/LO on the first idle cycle after each run.
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            else if (prev_busy) begin
                if (exp_q.size() == 0) chk("unexpected_run", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("commit_hi", HI, e.hi);
                    chk("commit_lo", LO, e.lo);
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        int sel;

        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        launch(MDU_OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(); read_check("mult");
        launch(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(); read_check("multu");
        launch(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(); read_check("div_neg");
        launch(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(); read_check("div_ovf");

        // Divide by zero keeps HI/LO; a second start mid-run must not relaunch.
        move_to(MDU_OP_MTHI, 32'h11);
        move_to(MDU_OP_MTLO, 32'h22);
        read_check("mtx");
        launch(MDU_OP_DIVU, 32'h1234_5678, 32'h0);
        repeat (3) @(negedge clk);
        A = 32'h99; B = 32'h3; MDUOp = MDU_OP_DIVU; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = MDU_OP_NONE;
        wait_idle(); read_check("divz");
        repeat (3) @(negedge clk);
        chk("no_relaunch", {31'b0, busy}, 32'd0);

        // MTLO while busy is dropped.
        launch(MDU_OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        A = 32'h1234; MDUOp = MDU_OP_MTLO;
        @(negedge clk);
        MDUOp = MDU_OP_NONE;
        wait_idle(); read_check("mtlo_busy");

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (sel >= 4) begin
                move_to(sel == 4 ? 4'(MDU_OP_MTHI) : 4'(MDU_OP_MTLO), a);
            end else begin
                op = 4'(sel + 1);
                launch(op, a, b);
                wait_idle();
            end
            read_check("rand");
        end

        // Async reset at DIV run cycle 4 zeroes state at once and cancels the commit.
        @(negedge clk);
        A = 32'd100; B = 32'd7; MDUOp = MDU_OP_DIV; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = MDU_OP_NONE;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        model_hi = '0; model_lo = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        read_check("post_rst");

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, next to the D-stage branch comparator in the operand datapath.
- The comparator answers in the same cycle. This block takes the same 32-bit operand pair and answers over several cycles.
- It owns the HI/LO registers and drives `busy` to the hazard/stall unit.
- It serves MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.

Parameters:
- MULT_LAT, default 5: cycles `busy` stays high for MULT/MULTU.
- DIV_LAT, default 10: cycles `busy` stays high for DIV/DIVU.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- A  input  32  operand rs (forwarded value).
- B  input  32  operand rt (forwarded value).
- MDUOp  input  4  operation code; `MDUOp_* constant from name.v.
- start  input  1  one-cycle pulse that launches MULT/MULTU/DIV/DIVU held in MDUOp.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  combinational read data: HI for MFHI, LO for MFLO, 0 otherwise.

Behaviour:
- Reset (reset==0, takes effect immediately, no clock needed):
  - busy=0, HI=0, LO=0, counter=0, pending result registers=0.
  - An in-flight operation is discarded.
- States: IDLE and RUN. Held as the counter value: IDLE when cnt==0.
- IDLE, start=1 with a mult/div MDUOp:
  - Latch the operation and compute the 64-bit result into pending {phi,plo}.
  - Load cnt with MULT_LAT or DIV_LAT; go to RUN.
  - busy rises in the next cycle.
- RUN: cnt decrements each cycle. busy=1 for exactly LAT cycles.
- Commit: on the edge where cnt goes 1->0, HI<=phi and LO<=plo, and busy falls at that same edge. New HI/LO are visible in the first cycle with busy=0.
- Arithmetic:
  - MULT: signed 32x32->64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32->64; same HI/LO split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0, DIV or DIVU): full DIV_LAT busy period, no commit; HI/LO keep their old values.
- MTHI/MTLO:
  - Write A into HI/LO at the clock edge when busy==0 and start==0.
  - Ignored while busy==1. The stall unit normally prevents this; the ignore is the defined fallback.
- start while busy==1: ignored, no relaunch.
- start with a non-mult/div MDUOp: no effect.
- MFHI/MFLO: combinational. During RUN they return the old HI/LO; the stall unit stalls on (start|busy).
- Simultaneous commit edge with MTHI/MTLO: cannot occur, since busy==1 blocks MTHI/MTLO.
- Reset asserted mid-RUN: returns to IDLE, and HI/LO are zeroed rather than committed.

Decomposition:
- name.v (shared define file) gains:
  - `MDUOp_NONE, `MDUOp_MULT, `MDUOp_MULTU, `MDUOp_DIV, `MDUOp_DIVU, `MDUOp_MTHI, `MDUOp_MTLO, `MDUOp_MFHI, `MDUOp_MFLO;
  - `MULT_LAT / `DIV_LAT defaults.
- One sub-module, mdu_calc: purely combinational, (A, B, MDUOp) -> {phi, plo, divzero}. It isolates the signed/unsigned arithmetic from the counter/commit sequencing in mdu_unit.

Test Plan:
- MULT A=0xFFFFFFFF, B=0x00000002, start pulse:
  - busy high exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFE;
  - MDUOut under MFLO=0xFFFFFFFE.
- MULTU same operands: after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002:
  - busy 10 cycles;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF: after 10 cycles LO=0x80000000, HI=0x00000000.
- DIVU by zero:
  - preload MTHI 0x11, MTLO 0x22, then DIVU B=0;
  - busy 10 cycles; HI stays 0x11 and LO stays 0x22.
  - Second start pulse during busy is ignored: busy still falls on cycle 10.
- MTLO A=0x1234 during MULT RUN: ignored, so LO shows the MULT result after commit.
- Reset driven low at DIV RUN cycle 4: busy=0, HI=0, LO=0 immediately without a clock edge, and no later commit.
